// File: rtl/fight_control.sv
`timescale 1ns/1ps
// fight_control: fight-scene sequencer. Runs the ready countdown and round timer,
// applies both players' attacks with per-player cooldowns, decides KO / timeout /
// draw, holds briefly and then pulses fight_to_end_scene to the scene controller.
//
// Ports:
//   clk, reset (async, active-low)
//   scene_state[3:0]   current scene, 4'b0011 = fight scene
//   sec_tick           one-cycle pulse per second
//   p1_atk/p1_heavy, p2_atk/p2_heavy   one-cycle attack requests
//   p1_hit_ok/p2_hit_ok                attack currently reaches the opponent
//   p1_hp/p2_hp[6:0]   current HP
//   time_left[6:0]     seconds remaining (ready count while in READY)
//   fight_state[2:0]   IDLE=0 READY=1 FIGHT=2 HOLD=3 DONE=4
//   winner[1:0]        00 none, 01 P1, 10 P2, 11 draw
//   p1_cd_busy/p2_cd_busy  cooldown counter non-zero
//   fight_to_end_scene one-cycle end pulse
module fight_control #(
  parameter int unsigned HP_MAX    = 100,
  parameter int unsigned DMG_LIGHT = 5,
  parameter int unsigned DMG_HEAVY = 12,
  parameter int unsigned CD_LIGHT  = 20,
  parameter int unsigned CD_HEAVY  = 40,
  parameter int unsigned READY_SEC = 3,
  parameter int unsigned ROUND_SEC = 60,
  parameter int unsigned END_HOLD  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] scene_state,
  input  logic       sec_tick,
  input  logic       p1_atk,
  input  logic       p1_heavy,
  input  logic       p2_atk,
  input  logic       p2_heavy,
  input  logic       p1_hit_ok,
  input  logic       p2_hit_ok,
  output logic [6:0] p1_hp,
  output logic [6:0] p2_hp,
  output logic [6:0] time_left,
  output logic [2:0] fight_state,
  output logic [1:0] winner,
  output logic       p1_cd_busy,
  output logic       p2_cd_busy,
  output logic       fight_to_end_scene
);

  localparam int unsigned CD_MAX  = (CD_HEAVY > CD_LIGHT) ? CD_HEAVY : CD_LIGHT;
  localparam int unsigned CD_W    = $clog2(CD_MAX + 1);
  localparam int unsigned HOLD_W  = $clog2(END_HOLD + 1);
  localparam logic [3:0]  SCENE_FIGHT = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_FIGHT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state, w_state_nx;
  logic [6:0]          r_p1_hp, w_p1_hp_nx;
  logic [6:0]          r_p2_hp, w_p2_hp_nx;
  logic [6:0]          r_time_left, w_time_nx;
  logic [1:0]          r_winner, w_winner_nx;
  logic [CD_W-1:0]     r_p1_cd, w_p1_cd_nx;
  logic [CD_W-1:0]     r_p2_cd, w_p2_cd_nx;
  logic                r_p1_busy, r_p2_busy;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nx;
  logic                r_end_pulse, w_end_nx;

  logic                w_in_scene;
  logic                w_p1_acc, w_p2_acc;
  logic [6:0]          w_p1_dmg, w_p2_dmg;
  logic [CD_W-1:0]     w_p1_cd_load, w_p2_cd_load;
  logic [CD_W-1:0]     w_p1_cd_dec, w_p2_cd_dec;
  logic [6:0]          w_p1_hp_hit, w_p2_hp_hit;
  logic [6:0]          w_time_dec;
  logic [1:0]          w_ko_winner, w_to_winner;

  // HP never wraps below zero
  function automatic logic [6:0] f_sat_sub(input logic [6:0] i_hp, input logic [6:0] i_dmg);
    return (i_hp > i_dmg) ? (i_hp - i_dmg) : 7'd0;
  endfunction

  assign w_in_scene = (scene_state == SCENE_FIGHT);

  // Attack acceptance: heavy wins over light, only with an idle cooldown
  assign w_p1_acc     = (p1_atk | p1_heavy) && (r_p1_cd == '0);
  assign w_p2_acc     = (p2_atk | p2_heavy) && (r_p2_cd == '0);
  assign w_p1_dmg     = p1_heavy ? 7'(DMG_HEAVY) : 7'(DMG_LIGHT);
  assign w_p2_dmg     = p2_heavy ? 7'(DMG_HEAVY) : 7'(DMG_LIGHT);
  assign w_p1_cd_load = p1_heavy ? CD_W'(CD_HEAVY) : CD_W'(CD_LIGHT);
  assign w_p2_cd_load = p2_heavy ? CD_W'(CD_HEAVY) : CD_W'(CD_LIGHT);
  assign w_p1_cd_dec  = (r_p1_cd != '0) ? (r_p1_cd - CD_W'(1)) : '0;
  assign w_p2_cd_dec  = (r_p2_cd != '0) ? (r_p2_cd - CD_W'(1)) : '0;

  // Post-hit HP; each player damages the other, both apply in the same cycle
  assign w_p2_hp_hit = (w_p1_acc && p1_hit_ok) ? f_sat_sub(r_p2_hp, w_p1_dmg) : r_p2_hp;
  assign w_p1_hp_hit = (w_p2_acc && p2_hit_ok) ? f_sat_sub(r_p1_hp, w_p2_dmg) : r_p1_hp;
  assign w_time_dec  = sec_tick ? (r_time_left - 7'd1) : r_time_left;

  // Winner decode on post-update values
  always_comb begin
    w_ko_winner = 2'b01;
    if ((w_p1_hp_hit == 7'd0) && (w_p2_hp_hit == 7'd0)) w_ko_winner = 2'b11;
    else if (w_p1_hp_hit == 7'd0)                       w_ko_winner = 2'b10;

    w_to_winner = 2'b11;
    if (w_p1_hp_hit > w_p2_hp_hit)      w_to_winner = 2'b01;
    else if (w_p2_hp_hit > w_p1_hp_hit) w_to_winner = 2'b10;
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_p1_hp     <= 7'(HP_MAX);
      r_p2_hp     <= 7'(HP_MAX);
      r_time_left <= 7'd0;
      r_winner    <= 2'b00;
      r_p1_cd     <= '0;
      r_p2_cd     <= '0;
      r_p1_busy   <= 1'b0;
      r_p2_busy   <= 1'b0;
      r_hold_cnt  <= '0;
      r_end_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_p1_hp     <= w_p1_hp_nx;
      r_p2_hp     <= w_p2_hp_nx;
      r_time_left <= w_time_nx;
      r_winner    <= w_winner_nx;
      r_p1_cd     <= w_p1_cd_nx;
      r_p2_cd     <= w_p2_cd_nx;
      r_p1_busy   <= (w_p1_cd_nx != '0);
      r_p2_busy   <= (w_p2_cd_nx != '0);
      r_hold_cnt  <= w_hold_nx;
      r_end_pulse <= w_end_nx;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nx  = r_state;
    w_p1_hp_nx  = r_p1_hp;
    w_p2_hp_nx  = r_p2_hp;
    w_time_nx   = r_time_left;
    w_winner_nx = r_winner;
    w_p1_cd_nx  = w_p1_cd_dec;
    w_p2_cd_nx  = w_p2_cd_dec;
    w_hold_nx   = r_hold_cnt;
    w_end_nx    = 1'b0;

    if ((r_state != S_IDLE) && !w_in_scene) begin
      // Leaving the fight scene aborts at once; winner and HP are kept
      w_state_nx = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_in_scene) begin
            w_state_nx  = S_READY;
            w_p1_hp_nx  = 7'(HP_MAX);
            w_p2_hp_nx  = 7'(HP_MAX);
            w_time_nx   = 7'(READY_SEC);
            w_winner_nx = 2'b00;
            w_p1_cd_nx  = '0;
            w_p2_cd_nx  = '0;
          end
        end
        S_READY: begin
          if (sec_tick) begin
            if (r_time_left == 7'd1) begin
              w_state_nx = S_FIGHT;
              w_time_nx  = 7'(ROUND_SEC);
            end else begin
              w_time_nx  = r_time_left - 7'd1;
            end
          end
        end
        S_FIGHT: begin
          w_p1_hp_nx = w_p1_hp_hit;
          w_p2_hp_nx = w_p2_hp_hit;
          w_time_nx  = w_time_dec;
          if (w_p1_acc) w_p1_cd_nx = w_p1_cd_load;
          if (w_p2_acc) w_p2_cd_nx = w_p2_cd_load;
          // KO outranks timeout when both happen together
          if ((w_p1_hp_hit == 7'd0) || (w_p2_hp_hit == 7'd0)) begin
            w_state_nx  = S_HOLD;
            w_winner_nx = w_ko_winner;
            w_hold_nx   = HOLD_W'(END_HOLD);
          end else if (w_time_dec == 7'd0) begin
            w_state_nx  = S_HOLD;
            w_winner_nx = w_to_winner;
            w_hold_nx   = HOLD_W'(END_HOLD);
          end
        end
        S_HOLD: begin
          // Counter runs END_HOLD..0, so DONE is entered END_HOLD+1 edges after HOLD
          if (r_hold_cnt == '0) begin
            w_state_nx = S_DONE;
            w_end_nx   = 1'b1;
          end else begin
            w_hold_nx  = r_hold_cnt - HOLD_W'(1);
          end
        end
        S_DONE: begin
          w_state_nx = S_DONE;
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  assign p1_hp              = r_p1_hp;
  assign p2_hp              = r_p2_hp;
  assign time_left          = r_time_left;
  assign fight_state        = r_state;
  assign winner             = r_winner;
  assign p1_cd_busy         = r_p1_busy;
  assign p2_cd_busy         = r_p2_busy;
  assign fight_to_end_scene = r_end_pulse;

endmodule
